// File: rtl/clock_hms_counter_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//   Constants and small helpers shared by the HH:MM:SS time-of-day counter.
//   DIGIT_W          : width of one BCD digit
//   SEC_TENS_MAX     : largest tens digit for seconds/minutes
//   ONES_MAX         : largest ones digit
//   MAX_HOUR_DEFAULT : default last hour before wrapping to 00 (24 h clock)
// ---------------------------------------------------------------------------
package clock_pkg;

    localparam int DIGIT_W          = 4;
    localparam int SEC_TENS_MAX     = 5;
    localparam int ONES_MAX         = 9;
    localparam int MAX_HOUR_DEFAULT = 23;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // Tens digit of a small decimal constant, as a BCD digit.
    function automatic bcd_t tens_of(input int value);
        return bcd_t'(value / 10);
    endfunction

    // Ones digit of a small decimal constant, as a BCD digit.
    function automatic bcd_t ones_of(input int value);
        return bcd_t'(value % 10);
    endfunction

endpackage

// File: rtl/clock_hms_counter_if.sv
// ---------------------------------------------------------------------------
// clock_hms_if
//   Bundles the control inputs and time-of-day outputs of clock_hms_counter.
//   Controls : sec_in (1 Hz square wave), run, clr, inc_min, inc_hr
//   Time     : hr_t/hr_o, min_t/min_o, sec_t/sec_o (BCD digits)
//   Pulses   : tick (one per sec_in rising edge), day_roll (midnight wrap)
//   master drives the controls and reads the time; slave is the counter.
// ---------------------------------------------------------------------------
interface clock_hms_if;
    import clock_pkg::*;

    logic sec_in;
    logic run;
    logic clr;
    logic inc_min;
    logic inc_hr;

    bcd_t hr_t;
    bcd_t hr_o;
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
    logic tick;
    logic day_roll;

    modport master (
        output sec_in, run, clr, inc_min, inc_hr,
        input  hr_t, hr_o, min_t, min_o, sec_t, sec_o, tick, day_roll
    );

    modport slave (
        input  sec_in, run, clr, inc_min, inc_hr,
        output hr_t, hr_o, min_t, min_o, sec_t, sec_o, tick, day_roll
    );

endinterface

// File: rtl/clock_hms_counter_bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
//   One registered BCD digit counting 0 .. MODULUS-1.
//   clk, reset : clock, asynchronous active-low reset
//   inc        : advance by one this cycle
//   clr        : synchronous clear to 0 (wins over inc)
//   wrap       : when incrementing, go to 0 regardless of value, no carry
//   value      : current digit (register)
//   carry      : combinational; high when this increment wraps naturally
// ---------------------------------------------------------------------------
module bcd_digit
    import clock_pkg::*;
#(
    parameter int MODULUS = ONES_MAX + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    input  logic wrap,
    output bcd_t value,
    output logic carry
);

    localparam bcd_t TOP = bcd_t'(MODULUS - 1);

    bcd_t value_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_reg <= '0;
        end else if (clr) begin
            value_reg <= '0;
        end else if (inc) begin
            if (wrap || value_reg == TOP) begin
                value_reg <= '0;
            end else begin
                value_reg <= value_reg + bcd_t'(1);
            end
        end
    end

    assign value = value_reg;
    // A forced wrap belongs to a multi-digit compare in the parent, so the
    // parent handles that case itself; only a natural 9->0 / 5->0 carries.
    assign carry = inc & ~clr & ~wrap & (value_reg == TOP);

endmodule

// File: rtl/clock_hms_counter.sv
// ---------------------------------------------------------------------------
// clock_hms_counter
//   Time-of-day counter HH:MM:SS in BCD, fed by a 1 Hz square wave that is
//   already synchronous to clk.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   bus      : clock_hms_if.slave (controls in, BCD digits/pulses out)
//   MAX_HOUR : last hour before wrapping to 00 (1..23)
//   SEC_IN_INIT : reset value of the sec_in delay flop; 1 means a sec_in
//                 that is already high at reset release does not tick.
// Priority per cycle: clr, then inc_min/inc_hr, then counting a second.
// tick follows every sec_in rising edge whatever run/clr/inc are doing.
// ---------------------------------------------------------------------------
module clock_hms_counter
    import clock_pkg::*;
#(
    parameter int MAX_HOUR    = MAX_HOUR_DEFAULT,
    parameter bit SEC_IN_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    clock_hms_if.slave  bus
);

    localparam bcd_t HR_T_MAX = tens_of(MAX_HOUR);
    localparam bcd_t HR_O_MAX = ones_of(MAX_HOUR);

    // Digit index map for the generated digit array.
    localparam int D_SEC_O = 0;
    localparam int D_SEC_T = 1;
    localparam int D_MIN_O = 2;
    localparam int D_MIN_T = 3;
    localparam int D_HR_O  = 4;
    localparam int N_DIG   = 5;

    logic sec_d_reg;
    logic tick_reg;
    logic day_roll_reg;
    bcd_t hr_t_reg;

    logic sec_edge;
    logic set_active;
    logic count_sec;
    logic min_carry_to_hr;
    logic hr_inc;
    logic hr_at_max;

    bcd_t digit_val   [N_DIG];
    logic digit_inc   [N_DIG];
    logic digit_clr   [N_DIG];
    logic digit_wrap  [N_DIG];
    logic digit_carry [N_DIG];

    // ------------------------------------------------------------------
    // Rising-edge detect on the 1 Hz input
    // ------------------------------------------------------------------
    assign sec_edge   = bus.sec_in & ~sec_d_reg;
    assign set_active = bus.inc_min | bus.inc_hr;
    // A second that coincides with clr or a set pulse is not counted.
    assign count_sec  = sec_edge & bus.run & ~bus.clr & ~set_active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_d_reg <= SEC_IN_INIT;
            tick_reg  <= 1'b0;
        end else begin
            sec_d_reg <= bus.sec_in;
            tick_reg  <= sec_edge;
        end
    end

    // ------------------------------------------------------------------
    // Carry chain wiring
    // ------------------------------------------------------------------
    // Setting minutes never ripples into hours: the minute that wraps
    // 59 -> 00 under inc_min is a set, not elapsed time.
    assign min_carry_to_hr = digit_carry[D_MIN_T] & ~bus.inc_min;
    assign hr_inc          = min_carry_to_hr | bus.inc_hr;
    assign hr_at_max       = (hr_t_reg == HR_T_MAX) && (digit_val[D_HR_O] == HR_O_MAX);

    always_comb begin
        for (int i = 0; i < N_DIG; i++) begin
            digit_inc[i]  = 1'b0;
            digit_clr[i]  = bus.clr;
            digit_wrap[i] = 1'b0;
        end
        digit_inc[D_SEC_O]  = count_sec;
        digit_inc[D_SEC_T]  = digit_carry[D_SEC_O];
        // inc_min zeroes the seconds so a freshly set minute starts clean.
        digit_clr[D_SEC_O]  = bus.clr | bus.inc_min;
        digit_clr[D_SEC_T]  = bus.clr | bus.inc_min;
        digit_inc[D_MIN_O]  = digit_carry[D_SEC_T] | bus.inc_min;
        digit_inc[D_MIN_T]  = digit_carry[D_MIN_O];
        digit_inc[D_HR_O]   = hr_inc;
        // The hour ones digit wraps to 0 at MAX_HOUR even mid-decade (e.g. 23).
        digit_wrap[D_HR_O]  = hr_at_max;
    end

    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
            localparam int MOD = (gi == D_SEC_T || gi == D_MIN_T)
                                 ? (SEC_TENS_MAX + 1) : (ONES_MAX + 1);
            bcd_digit #(
                .MODULUS (MOD)
            ) u_digit (
                .clk   (clk),
                .reset (reset),
                .inc   (digit_inc[gi]),
                .clr   (digit_clr[gi]),
                .wrap  (digit_wrap[gi]),
                .value (digit_val[gi]),
                .carry (digit_carry[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hours tens digit and the midnight wrap
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hr_t_reg     <= '0;
            day_roll_reg <= 1'b0;
        end else begin
            if (bus.clr) begin
                hr_t_reg <= '0;
            end else if (hr_inc && hr_at_max) begin
                hr_t_reg <= '0;
            end else if (digit_carry[D_HR_O]) begin
                hr_t_reg <= hr_t_reg + bcd_t'(1);
            end
            // Only elapsed time rolls the day; setting hours past MAX does not.
            day_roll_reg <= min_carry_to_hr & hr_at_max & ~bus.clr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all register-driven)
    // ------------------------------------------------------------------
    assign bus.sec_o    = digit_val[D_SEC_O];
    assign bus.sec_t    = digit_val[D_SEC_T];
    assign bus.min_o    = digit_val[D_MIN_O];
    assign bus.min_t    = digit_val[D_MIN_T];
    assign bus.hr_o     = digit_val[D_HR_O];
    assign bus.hr_t     = hr_t_reg;
    assign bus.tick     = tick_reg;
    assign bus.day_roll = day_roll_reg;

endmodule

// File: doc/clock_hms_counter.md
Name: clock_hms_counter

Overview:
- Downstream consumer of the 1 Hz divider output.
- Edge-detects the divider's square wave, which is synchronous to clk, and turns it into a one-cycle second tick.
- Keeps time-of-day as six BCD digits (HH:MM:SS) with carry chain, day-rollover pulse, run/pause and set controls.
- Feeds the display/7-segment stage.

Parameters:
- MAX_HOUR, 23, last hour value before wrap to 00; legal range 1..23 (23 = 24 h clock).
- SEC_IN_INIT, 1, reset value of the internal sec_in delay register; 1 suppresses a spurious tick when sec_in is already high at reset release.

Ports:
- clk  input  1  system clock, same domain as the divider.
- reset  input  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk upstream.
- sec_in  input  1  1 Hz square wave from divider, synchronous to clk.
- run  input  1  1 = count seconds; 0 = hold time (set inputs still work).
- clr  input  1  synchronous clear of all digits to 00:00:00.
- inc_min  input  1  single-cycle, debounced: minutes +1.
- inc_hr  input  1  single-cycle, debounced: hours +1.
- hr_t, hr_o  output  4 each  hours tens/ones, BCD.
- min_t, min_o  output  4 each  minutes tens/ones, BCD.
- sec_t, sec_o  output  4 each  seconds tens/ones, BCD.
- tick  output  1  one-cycle pulse, one per sec_in rising edge, independent of run.
- day_roll  output  1  one-cycle pulse when time wraps MAX_HOUR:59:59 -> 00:00:00.

Behaviour:
- Reset (reset=0), asynchronous: all digits 0, tick=0, day_roll=0, sec_d=SEC_IN_INIT.
- Edge detect: sec_d <= sec_in every cycle. edge = sec_in & ~sec_d. tick <= edge (registered).
- Latency: digits and tick update on the clk edge that ends the cycle in which edge=1. Both become visible together one cycle after sec_in is first sampled high.
- Per-cycle priority, highest first:
  - clr: all digits <- 0; inc and tick ignored for the digits; tick output still pulses.
  - inc_min and/or inc_hr:
    - inc_min: minutes +1, wrap 59 -> 00, no carry into hours; seconds <- 00.
    - inc_hr: hours +1, wrap MAX_HOUR -> 00.
    - Both high: both apply in the same cycle.
    - A coincident second edge is dropped for counting.
    - day_roll never fires from inc_hr.
  - edge & run: advance one second via the carry chain.
- Carry chain:
  - sec_o 9 -> 0 carries into sec_t; sec_t 5 with carry -> 0 carries into minutes.
  - Minutes work the same way (min_o, then min_t 5 -> 0) and carry into hours.
  - Hours compare as a two-digit BCD value against MAX_HOUR: equal plus carry -> 00 and day_roll=1 for exactly one cycle. Otherwise hr_o 9 -> 0 carries into hr_t.
- run=0: edge detector keeps tracking and tick still pulses; digits hold.
- Digits never leave legal BCD: tens of sec/min 0..5; hours 00..MAX_HOUR.
- All outputs are registers; no combinational path from input to output.
- Reset mid-second: the counter restarts at 00:00:00. The first tick follows the next sec_in rising edge after release.

Decomposition:
- Shared package clock_pkg:
  - BCD digit width constant (4).
  - SEC_TENS_MAX=5, ONES_MAX=9.
  - Default MAX_HOUR.
- One sub-module, bcd_digit:
  - Parameterized modulus.
  - Inputs: inc enable, sync clear, force-wrap.
  - Outputs: 4-bit value, carry-out.
  - Instanced for sec_o, sec_t, min_o, min_t and hr_o.
- Hours-pair wrap compare against MAX_HOUR lives in the top.

Test Plan:
- Reset/idle: hold reset=0 with sec_in=1, release -> no tick. Digits 00:00:00 until sec_in goes 0 then 1; then tick=1 for one cycle and sec_o=1 on that same cycle.
- Second/minute carry: run=1, 59 sec_in periods from 00:00:00 -> 00:00:59. Next edge -> 00:01:00, day_roll=0.
- Day rollover: 23 inc_hr, 59 inc_min, 59 seconds -> 23:59:59. Next edge -> 00:00:00 with day_roll high exactly one cycle.
- Set priority: at 12:59:30, inc_min in the same cycle as a sec_in rising edge -> 12:00:00 and tick=1. inc_hr+inc_min together at 23:00:10 -> 00:01:00, no day_roll.
- Pause and clear: run=0 for 5 sec_in periods at 00:00:07 -> 5 tick pulses, digits stay 00:00:07. clr -> 00:00:00.
- Parameter MAX_HOUR=11: from 11:59:59 one edge -> 00:00:00 plus day_roll. Async reset asserted mid-cycle at 05:06:07 -> digits 0 immediately, without waiting for a clk edge.
